// File: rtl/pll_phase_ctrl.sv
// PLL reset sequencer, lock qualifier and dynamic phase-step controller.
// Drives PLL reset and PHASE_STEP_N, and tracks the CLKOUT phase position modulo PHASE_MOD.
module pll_phase_ctrl #(
  parameter int unsigned RST_CYCLES         = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65535,
  parameter int unsigned STEP_GAP           = 4,
  parameter int unsigned PHASE_MOD          = 40,
  parameter logic [2:0]  PHASE_SEL_VAL      = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       pll_ready,
  input  logic       shift_req,
  input  logic       shift_dir,
  input  logic [5:0] shift_cnt,
  output logic       shift_busy,
  output logic       shift_ack,
  output logic [2:0] phase_sel,
  output logic       phase_dir,
  output logic       phase_step_n,
  output logic [5:0] phase_pos,
  output logic [7:0] relock_cnt,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_RST_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_READY,
    S_STEP_LO,
    S_STEP_HI
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [5:0]  rem, rem_nxt;
  logic [5:0]  pos_nxt;
  logic        dir_nxt;
  logic        ack_nxt;
  logic [7:0]  relock_nxt;
  logic        err_nxt;
  logic        lock_meta_p0;
  logic        lock_sync_p1;

  function automatic logic [5:0] pos_advance(input logic [5:0] p);
    return (p == 6'(PHASE_MOD - 1)) ? 6'd0 : p + 6'd1;
  endfunction

  function automatic logic [5:0] pos_retard(input logic [5:0] p);
    return (p == 6'd0) ? 6'(PHASE_MOD - 1) : p - 6'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_p0 <= 1'b0;
      lock_sync_p1 <= 1'b0;
    end else begin
      lock_meta_p0 <= pll_lock;
      lock_sync_p1 <= lock_meta_p0;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 32'd1;
    rem_nxt    = rem;
    pos_nxt    = phase_pos;
    dir_nxt    = phase_dir;
    ack_nxt    = 1'b0;
    relock_nxt = relock_cnt;
    err_nxt    = err_timeout;
    case (state)
      S_RST_PLL: begin
        if (cnt == RST_CYCLES - 1) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_sync_p1) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_TIMEOUT - 1) begin
          state_nxt = S_RST_PLL;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_sync_p1) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_STABLE_CYCLES - 1) begin
          state_nxt = S_READY;
          cnt_nxt   = '0;
        end
      end
      S_READY: begin
        cnt_nxt = '0;
        if (!lock_sync_p1) begin
          state_nxt  = S_RST_PLL;
          pos_nxt    = '0;
          relock_nxt = sat_inc8(relock_cnt);
        end else if (shift_req && !shift_ack) begin
          dir_nxt = shift_dir;
          rem_nxt = shift_cnt;
          if (shift_cnt == 6'd0) ack_nxt = 1'b1;
          else state_nxt = S_STEP_LO;
        end
      end
      S_STEP_LO: begin
        if (!lock_sync_p1) begin
          state_nxt  = S_RST_PLL;
          cnt_nxt    = '0;
          pos_nxt    = '0;
          relock_nxt = sat_inc8(relock_cnt);
        end else if (cnt == STEP_GAP - 1) begin
          state_nxt = S_STEP_HI;
          cnt_nxt   = '0;
        end
      end
      S_STEP_HI: begin
        if (!lock_sync_p1) begin
          state_nxt  = S_RST_PLL;
          cnt_nxt    = '0;
          pos_nxt    = '0;
          relock_nxt = sat_inc8(relock_cnt);
        end else if (cnt == STEP_GAP - 1) begin
          cnt_nxt = '0;
          rem_nxt = rem - 6'd1;
          pos_nxt = phase_dir ? pos_advance(phase_pos) : pos_retard(phase_pos);
          if (rem == 6'd1) begin
            state_nxt = S_READY;
            ack_nxt   = 1'b1;
          end else begin
            state_nxt = S_STEP_LO;
          end
        end
      end
      default: begin
        state_nxt = S_RST_PLL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RST_PLL;
      cnt         <= '0;
      phase_pos   <= '0;
      phase_dir   <= 1'b0;
      shift_ack   <= 1'b0;
      relock_cnt  <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      phase_pos   <= pos_nxt;
      phase_dir   <= dir_nxt;
      shift_ack   <= ack_nxt;
      relock_cnt  <= relock_nxt;
      err_timeout <= err_nxt;
    end
  end

  // Remaining-step count is only meaningful inside a shift, so it carries no reset
  always_ff @(posedge clk) begin
    rem <= rem_nxt;
  end

  assign pll_rst      = (state == S_RST_PLL);
  assign pll_ready    = (state == S_READY) || (state == S_STEP_LO) || (state == S_STEP_HI);
  assign shift_busy   = (state == S_STEP_LO) || (state == S_STEP_HI);
  assign phase_step_n = (state != S_STEP_LO);
  assign phase_sel    = PHASE_SEL_VAL;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: bring-up timing, lock glitch/loss/timeout and phase-shift sequences
// against a modular-arithmetic position model and closed-form timing expectations.
module tb_pll_phase_ctrl;
  localparam int RC = 4;
  localparam int LS = 8;
  localparam int SG = 2;
  localparam int PM = 40;
  localparam int LT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_rst, pll_ready;
  logic       shift_req = 1'b0;
  logic       shift_dir = 1'b0;
  logic [5:0] shift_cnt = 6'd0;
  logic       shift_busy, shift_ack;
  logic [2:0] phase_sel;
  logic       phase_dir, phase_step_n;
  logic [5:0] phase_pos;
  logic [7:0] relock_cnt;
  logic       err_timeout;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int exp_pos = 0;
  int pos_q[$];

  pll_phase_ctrl #(
    .RST_CYCLES(RC), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT(LT),
    .STEP_GAP(SG), .PHASE_MOD(PM), .PHASE_SEL_VAL(3'd0)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .pll_rst(pll_rst), .pll_ready(pll_ready),
    .shift_req(shift_req), .shift_dir(shift_dir), .shift_cnt(shift_cnt),
    .shift_busy(shift_busy), .shift_ack(shift_ack), .phase_sel(phase_sel),
    .phase_dir(phase_dir), .phase_step_n(phase_step_n), .phase_pos(phase_pos),
    .relock_cnt(relock_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int model_pos(input int p, input bit dir, input int n);
    int r;
    r = (p + (dir ? n : -n)) % PM;
    if (r < 0) r += PM;
    return r;
  endfunction

  // Reset, then raw lock is first sampled high at edge lock_edge (low only at glitch_edge).
  task automatic bring_up(input int lock_edge, input int glitch_edge, input bit req_lvl,
                          output int ready_at, output int rst_hi, output int err_first,
                          output int busy_seen);
    rst = 1'b1; pll_lock = 1'b0; shift_req = req_lvl; shift_dir = 1'b1; shift_cnt = 6'd3;
    tick(); tick();
    rst = 1'b0; cyc = 0;
    ready_at = -1; rst_hi = 0; err_first = -1; busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (pll_rst) rst_hi++;
      if (shift_busy) busy_seen++;
      if (err_timeout && err_first < 0) err_first = cyc;
      if (pll_ready) begin ready_at = cyc; break; end
      pll_lock = (lock_edge >= 0) && (cyc + 1 >= lock_edge) && (cyc + 1 != glitch_edge);
      tick();
    end
    shift_req = 1'b0;
    exp_pos = 0;
  endtask

  // Issue one request; step/busy windows are measured against the closed-form schedule.
  task automatic do_shift(input bit dir, input int n, output int ack_off, output int pos_at_ack,
                          output int step_bad, output int busy_bad, output int dir_bad,
                          output int ack_after);
    int t0, o, last;
    bit exp_low, exp_busy;
    shift_dir = dir; shift_cnt = 6'(n); shift_req = 1'b1;
    t0 = cyc; ack_off = -1; pos_at_ack = -1; step_bad = 0; busy_bad = 0; dir_bad = 0;
    ack_after = 1; last = int'(phase_pos);
    pos_q.delete();
    for (int i = 0; i < 300; i++) begin
      tick();
      o = cyc - t0;
      exp_busy = (o >= 1) && (o <= 2 * SG * n);
      exp_low  = exp_busy && (((o - 1) % (2 * SG)) < SG);
      if (phase_step_n !== !exp_low) step_bad++;
      if (shift_busy !== exp_busy) busy_bad++;
      if (shift_busy && phase_dir !== dir) dir_bad++;
      if (int'(phase_pos) != last) begin last = int'(phase_pos); pos_q.push_back(last); end
      if (shift_ack) begin ack_off = o; pos_at_ack = int'(phase_pos); shift_req = 1'b0; break; end
    end
    shift_req = 1'b0;
    tick();
    ack_after = int'(shift_ack);
  endtask

  task automatic test_reset();
    logic [23:0] got, want;
    rst = 1'b1; pll_lock = 1'b1; shift_req = 1'b1; shift_cnt = 6'd5;
    tick(); tick(); tick();
    got  = {pll_rst, pll_ready, shift_busy, shift_ack, phase_dir, phase_step_n,
            phase_pos, relock_cnt, err_timeout, phase_sel};
    want = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 8'd0, 1'b0, 3'd0};
    checks++;
    if (got !== want) begin errors++; $display("FAIL reset_values got=%h want=%h", got, want); end
    shift_req = 1'b0;
  endtask

  task automatic test_bringup();
    int ready_at, rst_hi, err_first, busy_seen;
    bring_up(20, -1, 1'b0, ready_at, rst_hi, err_first, busy_seen);
    checks++;
    if (rst_hi != RC) begin errors++; $display("FAIL bringup_rst_len got=%0d want=%0d", rst_hi, RC); end
    checks++;
    if (ready_at != 20 + 2 + LS) begin errors++; $display("FAIL bringup_ready_cycle got=%0d want=%0d", ready_at, 20 + 2 + LS); end
    checks++;
    if (err_first != -1 || err_timeout !== 1'b0) begin errors++; $display("FAIL bringup_err got=%0d want=-1", err_first); end
  endtask

  task automatic test_glitch();
    int ready_at, rst_hi, err_first, busy_seen;
    int glitch = 16;
    bring_up(10, glitch, 1'b0, ready_at, rst_hi, err_first, busy_seen);
    checks++;
    if (ready_at != (glitch + 1) + 2 + LS) begin errors++; $display("FAIL glitch_ready_cycle got=%0d want=%0d", ready_at, glitch + 1 + 2 + LS); end
    checks++;
    if (rst_hi != RC) begin errors++; $display("FAIL glitch_rst_len got=%0d want=%0d", rst_hi, RC); end
  endtask

  task automatic test_retard_noop();
    int ack_off, pa, sb, bb, db, aa;
    do_shift(1'b0, 1, ack_off, pa, sb, bb, db, aa);
    exp_pos = model_pos(exp_pos, 1'b0, 1);
    checks++;
    if (ack_off != 2 * SG + 1) begin errors++; $display("FAIL retard_ack_off got=%0d want=%0d", ack_off, 2 * SG + 1); end
    checks++;
    if (pa != exp_pos) begin errors++; $display("FAIL retard_wrap_pos got=%0d want=%0d", pa, exp_pos); end
    checks++;
    if (sb != 0 || bb != 0) begin errors++; $display("FAIL retard_step_window got=%0d/%0d want=0/0", sb, bb); end
    do_shift(1'b1, 0, ack_off, pa, sb, bb, db, aa);
    checks++;
    if (ack_off != 1) begin errors++; $display("FAIL noop_ack_off got=%0d want=1", ack_off); end
    checks++;
    if (sb != 0 || bb != 0 || pa != exp_pos) begin errors++; $display("FAIL noop_no_step got=%0d/%0d pos=%0d want=0/0 pos=%0d", sb, bb, pa, exp_pos); end
  endtask

  task automatic test_advance_wrap();
    int ack_off, pa, sb, bb, db, aa;
    do_shift(1'b0, 1, ack_off, pa, sb, bb, db, aa);
    exp_pos = model_pos(exp_pos, 1'b0, 1);
    checks++;
    if (pa != 38 || exp_pos != 38) begin errors++; $display("FAIL adv_setup_pos got=%0d want=38", pa); end
    do_shift(1'b1, 3, ack_off, pa, sb, bb, db, aa);
    exp_pos = model_pos(exp_pos, 1'b1, 3);
    checks++;
    if (ack_off != 13) begin errors++; $display("FAIL adv_ack_off got=%0d want=13", ack_off); end
    checks++;
    if (pos_q.size() != 3 || pos_q[0] != 39 || pos_q[1] != 0 || pos_q[2] != 1)
      begin errors++; $display("FAIL adv_pos_sequence got_len=%0d want=39,0,1", pos_q.size()); end
    checks++;
    if (sb != 0 || bb != 0 || db != 0 || pa != exp_pos)
      begin errors++; $display("FAIL adv_pulses got=%0d/%0d/%0d pos=%0d want=0/0/0 pos=%0d", sb, bb, db, pa, exp_pos); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] mask;
    shift_cnt = 6'd0; shift_dir = 1'b1; shift_req = 1'b1;
    for (int o = 1; o <= 6; o++) begin
      tick();
      mask[o-1] = shift_ack;
    end
    shift_req = 1'b0;
    tick();
    checks++;
    if (mask !== 6'b010101) begin errors++; $display("FAIL b2b_ack_pattern got=%b want=010101", mask); end
  endtask

  task automatic test_random_shifts();
    int ack_off, pa, sb, bb, db, aa, n;
    bit d;
    for (int it = 0; it < 10; it++) begin
      n = int'($urandom_range(0, 12));
      d = 1'($urandom_range(0, 1));
      do_shift(d, n, ack_off, pa, sb, bb, db, aa);
      exp_pos = model_pos(exp_pos, d, n);
      checks++;
      if (ack_off != ((n == 0) ? 1 : 2 * SG * n + 1)) begin errors++; $display("FAIL rnd_ack_off n=%0d got=%0d want=%0d", n, ack_off, (n == 0) ? 1 : 2 * SG * n + 1); end
      checks++;
      if (pa != exp_pos) begin errors++; $display("FAIL rnd_pos n=%0d dir=%0d got=%0d want=%0d", n, d, pa, exp_pos); end
      checks++;
      if (sb != 0 || bb != 0 || db != 0 || aa != 0) begin errors++; $display("FAIL rnd_timing n=%0d got=%0d/%0d/%0d/%0d want=0/0/0/0", n, sb, bb, db, aa); end
    end
  endtask

  task automatic test_lock_loss();
    int t0, rst_at, rst_hi, r, ready_at;
    bit ack_seen;
    logic [8:0] got;
    shift_dir = 1'b1; shift_cnt = 6'd5; shift_req = 1'b1;
    t0 = cyc; rst_at = -1; ack_seen = 1'b0; got = '1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (shift_ack) ack_seen = 1'b1;
      if (cyc - t0 == 5) pll_lock = 1'b0;
      if (pll_rst) begin
        rst_at = cyc;
        got = {shift_busy, phase_step_n, pll_ready, phase_pos};
        break;
      end
    end
    shift_req = 1'b0;
    checks++;
    if (rst_at < 0) begin errors++; $display("FAIL loss_no_pll_rst got=%0d want>=0", rst_at); end
    checks++;
    if (got !== {1'b0, 1'b1, 1'b0, 6'd0}) begin errors++; $display("FAIL loss_outputs got=%b want=010000000", got); end
    checks++;
    if (relock_cnt !== 8'd1) begin errors++; $display("FAIL loss_relock_cnt got=%0d want=1", relock_cnt); end
    rst_hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (shift_ack) ack_seen = 1'b1;
      if (!pll_rst) break;
      rst_hi++;
    end
    checks++;
    if (rst_hi != RC) begin errors++; $display("FAIL loss_rst_len got=%0d want=%0d", rst_hi, RC); end
    pll_lock = 1'b1; r = cyc; ready_at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (shift_ack) ack_seen = 1'b1;
      if (pll_ready) begin ready_at = cyc; break; end
    end
    exp_pos = 0;
    checks++;
    if (ack_seen) begin errors++; $display("FAIL loss_spurious_ack got=1 want=0"); end
    checks++;
    if (ready_at != r + 1 + 2 + LS) begin errors++; $display("FAIL loss_reready_cycle got=%0d want=%0d", ready_at, r + 1 + 2 + LS); end
    checks++;
    if (int'(phase_pos) != exp_pos || relock_cnt !== 8'd1) begin errors++; $display("FAIL loss_after_state pos=%0d relock=%0d want pos=0 relock=1", phase_pos, relock_cnt); end
  endtask

  task automatic test_timeout();
    int ready_at, rst_hi, err_first, busy_seen;
    bring_up(60, -1, 1'b1, ready_at, rst_hi, err_first, busy_seen);
    checks++;
    if (err_first != RC + LT) begin errors++; $display("FAIL timeout_err_cycle got=%0d want=%0d", err_first, RC + LT); end
    checks++;
    if (rst_hi != 2 * RC) begin errors++; $display("FAIL timeout_rst_cycles got=%0d want=%0d", rst_hi, 2 * RC); end
    checks++;
    if (ready_at != 60 + 2 + LS) begin errors++; $display("FAIL timeout_ready_cycle got=%0d want=%0d", ready_at, 60 + 2 + LS); end
    checks++;
    if (busy_seen != 0) begin errors++; $display("FAIL timeout_req_ignored got=%0d want=0", busy_seen); end
    tick(); tick();
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%0b want=1", err_timeout); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_retard_noop();
    test_advance_wrap();
    test_back_to_back();
    test_random_shifts();
    test_lock_loss();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
